// File: rtl/img_stream_pkg.sv
// Shared image-stream definitions: default frame geometry, window border and framer FSM states.
package img_stream_pkg;

  localparam int DEFAULT_IMAGE_WIDTH  = 640;
  localparam int DEFAULT_IMAGE_HEIGHT = 480;
  localparam int WINDOW_SIZE          = 7;
  localparam int DEFAULT_BORDER       = (WINDOW_SIZE - 1) / 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } framer_state_t;

  // Counter width for n positions, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pos_counter.sv
// Raster col/row counter. Holds the position of the next beat; clear restarts at (0,0),
// and clear with advance consumes (0,0) so the following beat lands on (1,0).
module pos_counter
  import img_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  localparam int CW = cnt_width(IMAGE_WIDTH),
  localparam int RW = cnt_width(IMAGE_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [CW-1:0] beat_col_o,
  output logic [RW-1:0] beat_row_o,
  output logic          last_col_o,
  output logic          last_row_o
);

  logic [CW-1:0] col_q, col_d, base_col;
  logic [RW-1:0] row_q, row_d, base_row;

  assign base_col   = clear_i ? '0 : col_q;
  assign base_row   = clear_i ? '0 : row_q;
  assign last_col_o = (base_col == CW'(IMAGE_WIDTH - 1));
  assign last_row_o = (base_row == RW'(IMAGE_HEIGHT - 1));
  assign beat_col_o = base_col;
  assign beat_row_o = base_row;

  always_comb begin
    col_d = base_col;
    row_d = base_row;
    if (advance_i) begin
      if (last_col_o) begin
        col_d = '0;
        row_d = last_row_o ? '0 : base_row + 1'b1;
      end else begin
        col_d = base_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/window_out_framer.sv
// Frames windowed-filter results into a raster stream with position, markers and border masking.
// Border masking is compiled in only when WINDOW_OUT_FRAMER_BORDER_MASK_EN is defined.
module window_out_framer
  import img_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = DEFAULT_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEFAULT_IMAGE_HEIGHT,
  parameter int BORDER       = DEFAULT_BORDER,
  parameter logic [DATA_WIDTH-1:0] BORDER_VALUE = '0,
  localparam int CW = cnt_width(IMAGE_WIDTH),
  localparam int RW = cnt_width(IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic [CW-1:0]         col,
  output logic [RW-1:0]         row,
  output logic                  busy
);

  framer_state_t state_q, state_d;

  logic [CW-1:0]         beat_col, col_q;
  logic [RW-1:0]         beat_row, row_q;
  logic                  last_col, last_row;
  logic [DATA_WIDTH-1:0] pix, dout_q;
  logic                  dout_valid_q, sof_q, eol_q, eof_q;

  pos_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT)
  ) u_pos (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (sync),
    .advance_i (din_valid),
    .beat_col_o(beat_col),
    .beat_row_o(beat_row),
    .last_col_o(last_col),
    .last_row_o(last_row)
  );

`ifdef WINDOW_OUT_FRAMER_BORDER_MASK_EN
  logic in_border;
  assign in_border = (int'(beat_col) < BORDER) || (int'(beat_col) >= IMAGE_WIDTH - BORDER) ||
                     (int'(beat_row) < BORDER) || (int'(beat_row) >= IMAGE_HEIGHT - BORDER);
  assign pix = in_border ? BORDER_VALUE : din;
`else
  logic unused_border_cfg;
  assign unused_border_cfg = ^{BORDER_VALUE, BORDER[0]};
  assign pix = din;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A beat qualified by sync opens a new frame at (0,0), so it keeps the FSM active.
  always_comb begin
    state_d = state_q;
    if (din_valid)  state_d = (last_col && last_row) ? IDLE : ACTIVE;
    else if (sync)  state_d = IDLE;
  end

  always_comb begin
    busy = (state_q == ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eol_q        <= 1'b0;
      eof_q        <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      dout_valid_q <= din_valid;
      sof_q        <= din_valid && (beat_col == '0) && (beat_row == '0);
      eol_q        <= din_valid && last_col;
      eof_q        <= din_valid && last_col && last_row;
      if (din_valid) begin
        dout_q <= pix;
        col_q  <= beat_col;
        row_q  <= beat_row;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;
  assign eol        = eol_q;
  assign eof        = eof_q;
  assign col        = col_q;
  assign row        = row_q;

endmodule

// File: tb/tb_window_out_framer.sv
// Directed bench for window_out_framer on an 8x8 frame with a 3-pixel border.
module tb_window_out_framer;

  localparam int W = 8;
  localparam int H = 8;
  localparam int B = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, sof, eol, eof, busy;
  logic [2:0] col, row;

  int checks = 0;
  int errors = 0;
  logic [7:0] hold_dout = '0;
  int hold_col = 0;
  int hold_row = 0;

  always #5 clk = ~clk;

  window_out_framer #(
    .DATA_WIDTH  (8),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .BORDER      (B),
    .BORDER_VALUE(8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sync      (sync),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .col       (col),
    .row       (row),
    .busy      (busy)
  );

  function automatic logic [7:0] exp_pix(input int c, input int r, input logic [7:0] d);
`ifdef WINDOW_OUT_FRAMER_BORDER_MASK_EN
    if (c < B || c >= W - B || r < B || r >= H - B) return 8'h00;
`endif
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted beat, checked one cycle later against the expected raster position.
  task automatic do_beat(input logic s, input logic [7:0] d, input int ec, input int er,
                         input logic ebusy);
    string t;
    logic [7:0] ed;
    din_valid = 1'b1; sync = s; din = d;
    @(posedge clk); #1;
    din_valid = 1'b0; sync = 1'b0;
    ed = exp_pix(ec, er, d);
    t = $sformatf("beat(%0d,%0d)", ec, er);
    chk({t, " dout_valid"}, 32'(dout_valid), 32'd1);
    chk({t, " col"}, 32'(col), 32'(ec));
    chk({t, " row"}, 32'(row), 32'(er));
    chk({t, " dout"}, 32'(dout), 32'(ed));
    chk({t, " sof"}, 32'(sof), 32'(ec == 0 && er == 0));
    chk({t, " eol"}, 32'(eol), 32'(ec == W - 1));
    chk({t, " eof"}, 32'(eof), 32'(ec == W - 1 && er == H - 1));
    chk({t, " busy"}, 32'(busy), 32'(ebusy));
    $display("beat sync=%0b din=%02h -> col=%0d row=%0d dout=%02h sof=%0b eol=%0b eof=%0b busy=%0b",
             s, d, col, row, dout, sof, eol, eof, busy);
    hold_dout = ed; hold_col = ec; hold_row = er;
  endtask

  task automatic do_idle(input logic s, input logic ebusy);
    din_valid = 1'b0; sync = s; din = 8'h5C;
    @(posedge clk); #1;
    sync = 1'b0;
    chk("idle dout_valid", 32'(dout_valid), 32'd0);
    chk("idle flags", 32'({sof, eol, eof}), 32'd0);
    chk("idle dout hold", 32'(dout), 32'(hold_dout));
    chk("idle col hold", 32'(col), 32'(hold_col));
    chk("idle row hold", 32'(row), 32'(hold_row));
    chk("idle busy", 32'(busy), 32'(ebusy));
    $display("idle sync=%0b -> dout_valid=%0b col=%0d row=%0d busy=%0b", s, dout_valid, col, row, busy);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " dout"}, 32'(dout), 32'd0);
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, " flags"}, 32'({sof, eol, eof}), 32'd0);
    chk({tag, " col"}, 32'(col), 32'd0);
    chk({tag, " row"}, 32'(row), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    $display("%s -> dout=%02h dout_valid=%0b col=%0d row=%0d busy=%0b", tag, dout, dout_valid, col, row, busy);
    hold_dout = '0; hold_col = 0; hold_row = 0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // Full gapless frame of 8'hAA
    for (int n = 0; n < W * H; n++) do_beat(1'b0, 8'hAA, n % W, n / W, n != W * H - 1);
    do_idle(1'b0, 1'b0);

    // Same frame with random gaps; din encodes its own position
    for (int n = 0; n < W * H; n++) begin
      do_beat(1'b0, 8'(n), n % W, n / W, n != W * H - 1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) do_idle(1'b0, n != W * H - 1);
    end

    // Sync with a beat at (5,2) restarts the raster
    for (int n = 0; n < 2 * W + 5; n++) do_beat(1'b0, 8'(n), n % W, n / W, 1'b1);
    do_beat(1'b1, 8'h77, 0, 0, 1'b1);
    do_beat(1'b0, 8'h78, 1, 0, 1'b1);

    // Sync without a beat clears the counters and idles the FSM
    do_idle(1'b1, 1'b0);
    do_beat(1'b0, 8'h10, 0, 0, 1'b1);

    // Reset arriving with the beat at (4,4) wins over it
    for (int n = 1; n < 4 * W + 4; n++) do_beat(1'b0, 8'(n), n % W, n / W, 1'b1);
    rst = 1'b1; din_valid = 1'b1; sync = 1'b1; din = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0; sync = 1'b0;
    chk_reset("mid-frame reset");
    do_beat(1'b0, 8'h21, 0, 0, 1'b1);

    // Two back-to-back frames
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("pre back-to-back reset");
    for (int n = 0; n < 2 * W * H; n++)
      do_beat(1'b0, 8'(n), n % W, (n / W) % H, (n % (W * H)) != W * H - 1);
    do_idle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
